// File: rtl/tia_object_position_counter.sv
// Horizontal position counter for one TIA object: counts motion clocks across a scan line
// and decodes the NUSIZ copy pattern and width into the object graphic.
module tia_object_position_counter #(
   parameter int PERIOD        = 160,
   parameter int CW            = 8,
   parameter int MAX_SIZE_LOG2 = 3
) (
   input  logic                     motck,
   input  logic                     reset,
   input  logic                     advance,
   input  logic                     object_reset,
   input  logic                     lock,
   input  logic                     enable,
   input  logic [2:0]               copies,
   input  logic [MAX_SIZE_LOG2-1:0] size,
   output logic                     obj,
   output logic [CW-1:0]            position
);

   localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
   localparam logic [CW:0]   PERIOD_X = (CW+1)'(PERIOD);
   localparam logic [CW:0]   S0       = '0;
   localparam logic [CW:0]   S16      = (CW+1)'(16);
   localparam logic [CW:0]   S32      = (CW+1)'(32);
   localparam logic [CW:0]   S64      = (CW+1)'(64);

   logic                     primary_ok;
   logic [MAX_SIZE_LOG2-1:0] eff_size;
   logic [CW:0]              win_len;
   logic [CW:0]              pos_x;
   logic                     draw16;
   logic                     draw32;
   logic                     draw64;

   always_ff @(posedge motck) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         position   <= '0;
         primary_ok <= 1'b0;
      end else if (lock || object_reset) begin
         position   <= '0;
         primary_ok <= 1'b0;
      end else if (advance) begin
         if (position == LAST) begin
            position   <= '0;
            primary_ok <= 1'b1;
         end else begin
            position <= position + CW'(1);
         end
      end
   end

   // Window test runs one bit wider than the counter so s + len can never alias back to 0.
   function automatic logic in_win(input logic [CW:0] p, input logic [CW:0] s,
                                   input logic [CW:0] len);
      return (p >= s) && (p < s + len) && (p < PERIOD_X);
   endfunction

   assign pos_x = {1'b0, position};

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      draw16   = 1'b0;
      draw32   = 1'b0;
      draw64   = 1'b0;
      eff_size = size;
      if (int'(size) > MAX_SIZE_LOG2) eff_size = MAX_SIZE_LOG2'(MAX_SIZE_LOG2);
      win_len  = (CW+1)'(1) << eff_size;

      case (copies)
         3'd1: draw16 = 1'b1;
         3'd2: draw32 = 1'b1;
         3'd3: begin draw16 = 1'b1; draw32 = 1'b1; end
         3'd4: draw64 = 1'b1;
         3'd6: begin draw32 = 1'b1; draw64 = 1'b1; end
         default: ;
      endcase

      obj = enable && !lock &&
            ((primary_ok && in_win(pos_x, S0, win_len)) ||
             (draw16 && in_win(pos_x, S16, win_len)) ||
             (draw32 && in_win(pos_x, S32, win_len)) ||
             (draw64 && in_win(pos_x, S64, win_len)));
   end

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Self-checking bench: two counters (PERIOD 160 and 80) share stimulus; a line-level model
// checks every cycle, and per-line hit maps are compared against hand-built position sets.
module tb_tia_object_position_counter;

   logic       motck;
   logic       reset;
   logic       advance;
   logic       object_reset;
   logic       lock;
   logic       enable;
   logic [2:0] copies;
   logic [2:0] size;
   logic       obj_a;
   logic [7:0] pos_a;
   logic       obj_b;
   logic [6:0] pos_b;

   tia_object_position_counter #(.PERIOD(160), .CW(8), .MAX_SIZE_LOG2(3)) u_dut_a (
      .motck(motck), .reset(reset), .advance(advance), .object_reset(object_reset),
      .lock(lock), .enable(enable), .copies(copies), .size(size),
      .obj(obj_a), .position(pos_a)
   );

   tia_object_position_counter #(.PERIOD(80), .CW(7), .MAX_SIZE_LOG2(3)) u_dut_b (
      .motck(motck), .reset(reset), .advance(advance), .object_reset(object_reset),
      .lock(lock), .enable(enable), .copies(copies), .size(size),
      .obj(obj_b), .position(pos_b)
   );

   initial motck = 1'b0;
   always #5 motck = ~motck;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Copy starts per NUSIZ value; bit0=0, bit1=16, bit2=32, bit3=64.
   localparam bit [3:0] COPY_MASK [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b0111,
                                          4'b1001, 4'b0001, 4'b1101, 4'b0001};
   localparam int PER [2] = '{160, 80};

   int mpos [2];
   bit mok  [2];

   function automatic bit exp_obj(input int pos, input bit ok, input int per);
      int starts [4];
      bit [3:0] mask;
      int w;
      starts = '{0, 16, 32, 64};
      if (!enable || lock) return 1'b0;
      mask = COPY_MASK[copies];
      w = 1 << ((int'(size) > 3) ? 3 : int'(size));
      for (int i = 0; i < 4; i++) begin
         if (mask[i] && (i != 0 || ok) && pos >= starts[i] && pos < starts[i] + w && pos < per)
            return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge motck) begin
      for (int k = 0; k < 2; k++) begin
         if (reset || lock || object_reset) begin
            mpos[k] <= 0;
            mok[k]  <= 1'b0;
         end else if (advance) begin
            if (mpos[k] == PER[k] - 1) begin
               mpos[k] <= 0;
               mok[k]  <= 1'b1;
            end else begin
               mpos[k] <= mpos[k] + 1;
            end
         end
      end
   end

   bit           cmp_en = 1'b0;
   bit           cap_en = 1'b0;
   logic [255:0] map_a;
   logic [255:0] map_b;
   int           obj_cycles;
   bit           pos_nz;

   always @(negedge motck) begin
      if (cmp_en) begin
         check("pos_a", 256'(pos_a), 256'(mpos[0]));
         check("obj_a", 256'(obj_a), 256'(exp_obj(mpos[0], mok[0], PER[0])));
         check("pos_b", 256'(pos_b), 256'(mpos[1]));
         check("obj_b", 256'(obj_b), 256'(exp_obj(mpos[1], mok[1], PER[1])));
      end
      if (cap_en) begin
         if (obj_a) begin
            map_a[pos_a] = 1'b1;
            obj_cycles   = obj_cycles + 1;
         end
         if (obj_b) map_b[pos_b] = 1'b1;
         if (pos_a != 8'd0) pos_nz = 1'b1;
      end
   end

   function automatic logic [255:0] rng(input int lo, input int hi);
      logic [255:0] r;
      r = '0;
      for (int i = lo; i <= hi; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge motck);
         #1;
      end
   endtask

   task automatic cap_start();
      map_a      = '0;
      map_b      = '0;
      obj_cycles = 0;
      pos_nz     = 1'b0;
      cap_en     = 1'b1;
   endtask

   task automatic cap_line(input int n);
      cap_start();
      tick(n);
      cap_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; advance = 1'b0; object_reset = 1'b0; lock = 1'b0;
      enable = 1'b1; copies = 3'd0; size = 3'd0;
      tick(2);
      cmp_en = 1'b1;
      tick(1);
      check("reset_pos", 256'(pos_a), 256'(0));
      check("reset_obj", 256'(obj_a), 256'(0));

      // Line 0 after reset: primary copy suppressed; afterwards only position 0.
      reset = 1'b0; advance = 1'b1;
      cap_line(160);
      check("line0_none", map_a, '0);
      cap_line(160);
      check("line1_primary", map_a, rng(0, 0));

      copies = 3'd3;
      cap_line(160);
      check("copies3", map_a, rng(0, 0) | rng(16, 16) | rng(32, 32));
      copies = 3'd6;
      cap_line(160);
      check("copies6", map_a, rng(0, 0) | rng(32, 32) | rng(64, 64));

      copies = 3'd4; size = 3'd3;
      cap_line(160);
      check("copies4_sz3_p160", map_a, rng(0, 7) | rng(64, 71));
      check("copies4_sz3_p80", map_b, rng(0, 7) | rng(64, 71));

      // Size above the maximum clamps to 8 wide; enable drop cuts the window mid-way.
      copies = 3'd0; size = 3'd7;
      cap_start();
      tick(4);
      enable = 1'b0;
      tick(156);
      cap_en = 1'b0;
      enable = 1'b1;
      check("clamp_enable_cut", map_a, rng(0, 3));

      copies = 3'd1; size = 3'd0;
      tick(100);
      check("pos_at_100", 256'(pos_a), 256'(100));
      object_reset = 1'b1;
      tick(1);
      object_reset = 1'b0;
      check("objreset_pos0", 256'(pos_a), 256'(0));
      cap_line(160);
      check("objreset_no_primary", map_a, rng(16, 16));
      cap_line(160);
      check("objreset_restored", map_a, rng(0, 0) | rng(16, 16));

      lock = 1'b1;
      cap_line(50);
      lock = 1'b0;
      check("lock_obj_blank", map_a, '0);
      check("lock_pos_held", 256'(pos_nz), 256'(0));
      check("lock_pos0", 256'(pos_a), 256'(0));
      cap_line(160);
      check("unlock_no_primary", map_a, rng(16, 16));
      cap_line(160);
      check("unlock_restored", map_a, rng(0, 0) | rng(16, 16));

      // Half-rate advance: every count is held two cycles, so windows stretch 2x.
      copies = 3'd3; size = 3'd2;
      cap_start();
      for (int i = 0; i < 20; i++) begin
         advance = i[0];
         tick(1);
      end
      check("halfrate_pos10", 256'(pos_a), 256'(10));
      for (int i = 20; i < 320; i++) begin
         advance = i[0];
         tick(1);
      end
      cap_en  = 1'b0;
      advance = 1'b1;
      check("halfrate_wrap", 256'(pos_a), 256'(0));
      check("halfrate_map", map_a, rng(0, 3) | rng(16, 19) | rng(32, 35));
      check("halfrate_cycles", 256'(obj_cycles), 256'(24));

      copies = 3'd0; size = 3'd0;
      tick(50);
      reset = 1'b1;
      tick(3);
      check("midreset_pos", 256'(pos_a), 256'(0));
      check("midreset_obj", 256'(obj_a), 256'(0));
      reset = 1'b0;
      cap_line(160);
      check("postreset_no_primary", map_a, '0);
      cap_line(160);
      check("postreset_primary", map_a, rng(0, 0));

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tia_object_position_counter.md
TIA_OBJECT_POSITION_COUNTER -- requirements
Module: tia_object_position_counter

Interface
REQ-001 SHALL have parameter PERIOD, default 160, meaning counts per scan line; legal range 80..255.
REQ-002 SHALL have parameter CW, default 8, meaning counter width; CW SHALL satisfy 2^CW >= PERIOD.
REQ-003 SHALL have parameter MAX_SIZE_LOG2, default 3, meaning the largest object width is 2^MAX_SIZE_LOG2 counts.
REQ-004 SHALL have port motck  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port advance  input  1  the counter steps this cycle (pixel clock enable OR motion pulse).
REQ-007 SHALL have port object_reset  input  1  position strobe that reloads the counter to 0.
REQ-008 SHALL have port lock  input  1  lock-to-player; holds the counter at 0 and blanks the output.
REQ-009 SHALL have port enable  input  1  the object is visible when high.
REQ-010 SHALL have port copies  input  3  copy pattern (NUSIZ bits 2:0).
REQ-011 SHALL have port size  input  MAX_SIZE_LOG2 bits  log2 of the object width in counts.
REQ-012 SHALL have port obj  output  1  object graphic.
REQ-013 SHALL have port position  output  CW  current counter value.

Function
REQ-014 position SHALL count 0..PERIOD-1; on a cycle with advance=1 it SHALL go to position+1, or to 0 when position=PERIOD-1 (wrap).
REQ-015 With advance=0, position SHALL hold.
REQ-016 With object_reset=1, position SHALL load 0 on the next edge regardless of advance, and primary_ok SHALL clear.
REQ-017 primary_ok (internal) SHALL set on every natural wrap (PERIOD-1 -> 0 with advance=1).
REQ-018 With lock=1, position SHALL load 0 each cycle and primary_ok SHALL clear; lock SHALL take priority over object_reset and advance.
REQ-019 Copy start sets by copies value: 0:{0}; 1:{0,16}; 2:{0,32}; 3:{0,16,32}; 4:{0,64}; 5:{0}; 6:{0,32,64}; 7:{0}.
REQ-020 The start at 0 SHALL be drawn only when primary_ok=1; the starts at 16, 32 and 64 SHALL be drawn unconditionally.
REQ-021 obj SHALL be combinational from the registered position, so it has zero latency relative to position.
REQ-022 obj SHALL be 1 iff enable=1, lock=0 and position lies in [s, s+2^size-1] for some drawn start s.
REQ-023 A copy window SHALL NOT wrap past PERIOD-1; counts at or beyond PERIOD SHALL NOT be drawn.
REQ-024 Changes to copies, size and enable SHALL take effect in the same cycle they occur, including mid-window.
REQ-025 A size value above MAX_SIZE_LOG2 SHALL be clamped to MAX_SIZE_LOG2.
REQ-026 Counter arithmetic SHALL be unsigned CW-bit; window-end comparison SHALL use CW+1 bits so that no overflow aliasing occurs.

Reset
REQ-027 While reset=1, position SHALL be 0 and primary_ok SHALL be 0, so obj SHALL be 0 during reset and the primary copy SHALL be suppressed for the first line after reset.
REQ-028 reset SHALL dominate lock, object_reset and advance.
REQ-029 Deasserting reset mid-line SHALL resume counting from 0 on the next advance.

Verification
REQ-030 Bench SHALL check: reset, then advance=1 continuously, copies=0, size=0, enable=1 -> obj=0 throughout line 0; on lines 1+ obj=1 only at position 0.
REQ-031 Bench SHALL check: after one full line, copies=3 -> obj=1 at positions 0, 16 and 32 only; copies=6 -> obj=1 at 0, 32 and 64 only.
REQ-032 Bench SHALL check: copies=4, size=3 -> obj=1 for positions 0-7 and 64-71, 0 elsewhere; with PERIOD=80 and copies=4, size=3 -> obj=1 for 64-71 with no wrap into 0.
REQ-033 Bench SHALL check: object_reset pulsed at position 100 -> position=0 on the next edge, no primary copy that line, copy at 16 still drawn, primary copy restored after the next wrap.
REQ-034 Bench SHALL check: lock=1 for 50 cycles -> position stays 0 and obj stays 0; after lock falls, the first line has no primary copy.
REQ-035 Bench SHALL check: advance toggled 1/0 alternately -> position advances once per two cycles and each obj window lasts 2x its nominal length in cycles.
